e_mdu: RTL and testbench

- Multiply/divide unit in the E stage; the write side of the HI/LO register pair.
- Accepts mult/multu/div/divu/mthi/mtlo from the E-stage decode.
- Models the fixed MIPS pipeline latency with a busy counter.
- Holds the architectural HI and LO registers. The E-stage HI/LO read mux consumes them as E_RDHI/E_RDLO for mfhi/mflo, and the hazard unit stalls on E_Start | E_Busy.

---
 rtl/e_mdu.sv | 142 ++++++++++++++
 tb/tb_e_mdu.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO; results commit MULT_CYCLES/DIV_CYCLES after the start edge.
// No handshake: E_Busy is held high for the whole operation and the hazard unit stalls on E_Start | E_Busy.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDOp,
    input  logic        E_Start,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    input  logic        Req,
    output logic        E_Busy,
    output logic [31:0] E_RDHI,
    output logic [31:0] E_RDLO
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   hi, hi_nxt, lo, lo_nxt;
    logic [31:0]   pend_hi, pend_hi_nxt, pend_lo, pend_lo_nxt;
    logic          pend_wr, pend_wr_nxt;

    // Arithmetic results for the operands presented this cycle
    logic signed [63:0] mul_a, mul_b, prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] div_a, div_b, quo_s, rem_s;
    logic [31:0]        divu_b, quo_u, rem_u;
    logic               rt_zero, div_ovf;
    logic [31:0]        res_hi, res_lo;
    logic               res_wr;
    logic               md_op;

    assign rt_zero = (E_RT == 32'd0);
    // 0x80000000 / -1 is steered to a divide-by-one, which yields the required LO=0x80000000, HI=0
    assign div_ovf = (E_RS == 32'h8000_0000) && (E_RT == 32'hFFFF_FFFF);

    always_comb begin
        mul_a  = {{32{E_RS[31]}}, E_RS};
        mul_b  = {{32{E_RT[31]}}, E_RT};
        prod_s = mul_a * mul_b;
        prod_u = {32'd0, E_RS} * {32'd0, E_RT};
        div_a  = E_RS;
        div_b  = (rt_zero || div_ovf) ? 32'sd1 : E_RT;
        quo_s  = div_a / div_b;
        rem_s  = div_a % div_b;
        divu_b = rt_zero ? 32'd1 : E_RT;
        quo_u  = E_RS / divu_b;
        rem_u  = E_RS % divu_b;
    end

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b1;
        md_op  = 1'b1;
        case (E_MDOp)
            OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            OP_DIV:   begin res_hi = rem_s; res_lo = quo_s; res_wr = !rt_zero; end
            OP_DIVU:  begin res_hi = rem_u; res_lo = quo_u; res_wr = !rt_zero; end
            default:  begin md_op = 1'b0; res_wr = 1'b0; end
        endcase
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hi_nxt      = hi;
        lo_nxt      = lo;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_wr_nxt = pend_wr;
        case (state)
            IDLE: begin
                if (!Req) begin
                    if (E_Start && md_op) begin
                        state_nxt   = BUSY;
                        cnt_nxt     = (E_MDOp == OP_MULT || E_MDOp == OP_MULTU) ? MULT_N : DIV_N;
                        pend_hi_nxt = res_hi;
                        pend_lo_nxt = res_lo;
                        pend_wr_nxt = res_wr;
                    end else if (!E_Start && E_MDOp == OP_MTHI) begin
                        hi_nxt = E_RS;
                    end else if (!E_Start && E_MDOp == OP_MTLO) begin
                        lo_nxt = E_RS;
                    end
                end
            end
            BUSY: begin
                // Req is not consulted: the owning instruction has already retired
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                    if (pend_wr) begin
                        hi_nxt = pend_hi;
                        lo_nxt = pend_lo;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_wr <= pend_wr_nxt;
        end
    end

    assign E_Busy = (state == BUSY);
    assign E_RDHI = hi;
    assign E_RDLO = lo;
endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: inputs change and outputs are sampled on the falling edge.
module tb_e_mdu;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDOp;
    logic        E_Start;
    logic [31:0] E_RS, E_RT;
    logic        Req;
    logic        E_Busy;
    logic [31:0] E_RDHI, E_RDLO;

    int passed = 0;
    int total  = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_MDOp(E_MDOp), .E_Start(E_Start),
        .E_RS(E_RS), .E_RT(E_RT), .Req(Req),
        .E_Busy(E_Busy), .E_RDHI(E_RDHI), .E_RDLO(E_RDLO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        E_MDOp  = 4'd0;
        E_Start = 1'b0;
        E_RS    = 32'd0;
        E_RT    = 32'd0;
        Req     = 1'b0;
    endtask

    // Start an op, check HI/LO hold, count Busy cycles, then check the committed values.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input int exp_n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit req_mid);
        logic [31:0] old_hi, old_lo;
        int n;
        old_hi = E_RDHI;
        old_lo = E_RDLO;
        E_MDOp = op; E_Start = 1'b1; E_RS = rs; E_RT = rt;
        @(negedge clk);
        idle_inputs();
        n = 0;
        while (E_Busy === 1'b1 && n < 40) begin
            if (n == 0 || n == exp_n - 1) begin
                chk({tag, " hold hi"}, E_RDHI, old_hi);
                chk({tag, " hold lo"}, E_RDLO, old_lo);
            end
            Req = (req_mid && n >= 1 && n <= 2);
            n++;
            @(negedge clk);
        end
        Req = 1'b0;
        chk({tag, " busy cycles"}, 32'(n), 32'(exp_n));
        chk({tag, " hi"}, E_RDHI, exp_hi);
        chk({tag, " lo"}, E_RDLO, exp_lo);
    endtask

    initial begin
        bit stray;
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, E_Busy}, 32'd0);
        chk("reset hi", E_RDHI, 32'd0);
        chk("reset lo", E_RDLO, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("mult -2*3", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("multu max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("div -7/2", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu 7/2", 4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0);
        run_op("div ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 1'b0);

        E_MDOp = 4'd5; E_RS = 32'h11;
        @(negedge clk);
        idle_inputs();
        chk("mthi hi", E_RDHI, 32'h11);
        chk("mthi busy", {31'd0, E_Busy}, 32'd0);
        E_MDOp = 4'd6; E_RS = 32'h22;
        @(negedge clk);
        idle_inputs();
        chk("mtlo lo", E_RDLO, 32'h22);
        chk("mtlo hi kept", E_RDHI, 32'h11);

        run_op("divu by 0", 4'd4, 32'd1234, 32'd0, 10, 32'h11, 32'h22, 1'b0);

        // Mult opcode without the start strobe, and start with a non-MD opcode
        E_MDOp = 4'd1; E_RS = 32'd9; E_RT = 32'd9;
        @(negedge clk);
        idle_inputs();
        chk("op no start busy", {31'd0, E_Busy}, 32'd0);
        E_MDOp = 4'd5; E_Start = 1'b1; E_RS = 32'h77;
        @(negedge clk);
        idle_inputs();
        chk("start mthi ignored hi", E_RDHI, 32'h11);
        chk("start mthi busy", {31'd0, E_Busy}, 32'd0);

        E_MDOp = 4'd1; E_Start = 1'b1; E_RS = 32'd6; E_RT = 32'd7; Req = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("req mult busy", {31'd0, E_Busy}, 32'd0);
        repeat (6) @(negedge clk);
        chk("req mult hi", E_RDHI, 32'h11);
        chk("req mult lo", E_RDLO, 32'h22);

        E_MDOp = 4'd6; E_RS = 32'h99; Req = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("req mtlo lo", E_RDLO, 32'h22);

        run_op("mult req mid", 4'd1, 32'd4, 32'd5, 5, 32'd0, 32'd20, 1'b1);

        // Reset lands on the 4th Busy cycle of a div
        E_MDOp = 4'd3; E_Start = 1'b1; E_RS = 32'd100; E_RT = 32'd7;
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        chk("mid busy before reset", {31'd0, E_Busy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mid reset busy", {31'd0, E_Busy}, 32'd0);
        chk("mid reset hi", E_RDHI, 32'd0);
        chk("mid reset lo", E_RDLO, 32'd0);
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (E_Busy !== 1'b0 || E_RDHI !== 32'd0 || E_RDLO !== 32'd0) stray = 1'b1;
        end
        chk("no commit after reset", {31'd0, stray}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
